// File: rtl/data_memory_bw_pkg.sv
// Shared definitions for the byte-addressable data memory: access sizes,
// FSM states and lane/alignment decode helpers.
package data_memory_bw_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            SIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_mask = 4'b1111;
            default:   lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bw_load_aligner.sv
// Extracts the addressed byte/half/word from a memory word and
// sign- or zero-extends it to the full data width.
module load_aligner
    import data_memory_bw_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] word,
    input  logic [1:0]         addr_lo,
    input  logic [1:0]         size,
    input  logic               sign_ext,
    output logic [NB_DATA-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (size)
            SIZE_BYTE: result = {{(NB_DATA-8){sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = {{(NB_DATA-16){sign_ext & half_sel[15]}}, half_sel};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/data_memory_bw.sv
// MEM-stage data memory with byte/half/word access, post-reset clear sweep
// and a read-only debug port.
module data_memory_bw
    import data_memory_bw_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NB_ADDR-1:0] address,
    input  logic               write_enable,
    input  logic               read_enable,
    input  logic [1:0]         size,
    input  logic               sign_ext,
    input  logic [NB_DATA-1:0] data_in,
    output logic [NB_DATA-1:0] data_out,
    output logic               read_valid,
    output logic               misaligned,
    output logic               busy,
    input  logic [NB_ADDR-3:0] dbg_address,
    output logic [NB_DATA-1:0] dbg_data
);

    localparam int DEPTH = 2 ** (NB_ADDR - 2);

    if (NB_DATA != 32) begin : g_bad_width
        $error("data_memory_bw: NB_DATA must be 32");
    end

    logic [NB_DATA-1:0] mem [DEPTH];

    state_t             state;
    logic [NB_ADDR-3:0] ptr;
    logic [NB_ADDR-3:0] word_idx;
    logic [1:0]         addr_lo;
    logic               bad_align;
    logic [3:0]         lane_en;
    logic               store_ok;
    logic               load_ok;
    logic [NB_DATA-1:0] store_word;
    logic [NB_DATA-1:0] load_word;

    always_comb begin
        word_idx  = address[NB_ADDR-1:2];
        addr_lo   = address[1:0];
        bad_align = is_misaligned(size, addr_lo);
        lane_en   = lane_mask(size, addr_lo);
        store_ok  = (state == ST_READY) && write_enable && !bad_align;
        load_ok   = (state == ST_READY) && read_enable && !bad_align;
        // Replicating the right-aligned store data puts it on every lane, so
        // the lane enables alone select where it lands.
        case (size)
            SIZE_BYTE: store_word = {4{data_in[7:0]}};
            SIZE_HALF: store_word = {2{data_in[15:0]}};
            default:   store_word = data_in;
        endcase
    end

    load_aligner #(
        .NB_DATA (NB_DATA)
    ) u_load_aligner (
        .word     (mem[word_idx]),
        .addr_lo  (addr_lo),
        .size     (size),
        .sign_ext (sign_ext),
        .result   (load_word)
    );

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[ptr] <= '0;
        end else if (store_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_INIT;
            ptr        <= '0;
            data_out   <= '0;
            read_valid <= 1'b0;
            misaligned <= 1'b0;
            busy       <= 1'b1;
            dbg_data   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    read_valid <= 1'b0;
                    misaligned <= 1'b0;
                    dbg_data   <= '0;
                    ptr        <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    read_valid <= load_ok;
                    misaligned <= (write_enable || read_enable) && bad_align;
                    dbg_data   <= mem[dbg_address];
                    if (load_ok) begin
                        data_out <= load_word;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_bw.sv
// Scoreboard bench for data_memory_bw: expected load results are queued at
// issue and compared when read_valid is sampled.
module tb_data_memory_bw;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 7;

    typedef struct packed {
        logic [6:0]  a;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] e;
    } ld_t;

    logic               clk;
    logic               rst;
    logic [NB_ADDR-1:0] address;
    logic               write_enable;
    logic               read_enable;
    logic [1:0]         size;
    logic               sign_ext;
    logic [NB_DATA-1:0] data_in;
    logic [NB_DATA-1:0] data_out;
    logic               read_valid;
    logic               misaligned;
    logic               busy;
    logic [NB_ADDR-3:0] dbg_address;
    logic [NB_DATA-1:0] dbg_data;

    logic [31:0] exp_q [$];
    logic [31:0] last_exp;
    int          n_cmp;
    int          n_mis;

    data_memory_bw #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .size         (size),
        .sign_ext     (sign_ext),
        .data_in      (data_in),
        .data_out     (data_out),
        .read_valid   (read_valid),
        .misaligned   (misaligned),
        .busy         (busy),
        .dbg_address  (dbg_address),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue_load(input logic [6:0] a, input logic [1:0] sz, input logic sx,
                              input logic [31:0] e);
        @(negedge clk);
        address = a; size = sz; sign_ext = sx; read_enable = 1'b1; write_enable = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    task automatic issue_store(input logic [6:0] a, input logic [1:0] sz, input logic [31:0] d);
        @(negedge clk);
        address = a; size = sz; data_in = d; write_enable = 1'b1; read_enable = 1'b0;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic test_reset();
        int cycles;
        int bad;
        ld_t tbl [2];
        logic [31:0] got;
        rst = 1'b0;
        address = '0; write_enable = 1'b0; read_enable = 1'b0; size = 2'b10;
        sign_ext = 1'b0; data_in = '0; dbg_address = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data_out, read_valid, misaligned, busy, dbg_data} !== {32'h0, 1'b0, 1'b0, 1'b1, 32'h0}) begin
            n_mis++;
            $display("FAIL reset_outputs: data_out=%h rv=%b mis=%b busy=%b dbg=%h, need 0/0/0/1/0",
                     data_out, read_valid, misaligned, busy, dbg_data);
        end
        // Requests during the sweep must be ignored entirely.
        rst = 1'b1;
        address = 7'h00; size = 2'b10; data_in = 32'hFFFF_FFFF;
        write_enable = 1'b1; read_enable = 1'b1;
        cycles = 0; bad = 0;
        while (busy === 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (read_valid !== 1'b0 || misaligned !== 1'b0) bad++;
            if (cycles == 16) address = 7'h02;
        end
        write_enable = 1'b0; read_enable = 1'b0;
        n_cmp++;
        if (cycles != 32) begin
            n_mis++;
            $display("FAIL busy_length: busy cycles=%0d, need 32", cycles);
        end
        n_cmp++;
        if (bad != 0) begin
            n_mis++;
            $display("FAIL init_ignores_requests: pulses seen=%0d, need 0", bad);
        end
        tbl[0] = '{7'h00, 2'b10, 1'b0, 32'h0000_0000};
        tbl[1] = '{7'h7C, 2'b10, 1'b0, 32'h0000_0000};
        foreach (tbl[i]) begin
            issue_load(tbl[i].a, tbl[i].sz, tbl[i].sx, tbl[i].e);
            n_cmp++;
            if (read_valid !== 1'b1) begin
                n_mis++;
                $display("FAIL reset_load_rv[%0d]: read_valid=%b, need 1", i, read_valid);
            end
            if (exp_q.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL reset_load_queue[%0d]: scoreboard empty, need 1 entry", i);
            end else begin
                got = exp_q.pop_front();
                last_exp = got;
                n_cmp++;
                if (data_out !== got) begin
                    n_mis++;
                    $display("FAIL reset_load_data[%0d]: data_out=%h, need %h", i, data_out, got);
                end
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] got;
        issue_store(7'h04, 2'b10, 32'h1234_5678);
        issue_load(7'h04, 2'b10, 1'b0, 32'h1234_5678);
        n_cmp++;
        if (read_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL word_rv: read_valid=%b, need 1", read_valid);
        end
        got = exp_q.pop_front();
        last_exp = got;
        n_cmp++;
        if (data_out !== got) begin
            n_mis++;
            $display("FAIL word_data: data_out=%h, need %h", data_out, got);
        end
        @(negedge clk);
        n_cmp++;
        if (read_valid !== 1'b0 || data_out !== last_exp) begin
            n_mis++;
            $display("FAIL word_pulse_hold: rv=%b data_out=%h, need 0 and %h", read_valid, data_out, last_exp);
        end
    endtask

    task automatic test_byte_half();
        ld_t tbl [6];
        logic [31:0] got;
        issue_store(7'h05, 2'b00, 32'h0000_00AB);
        issue_store(7'h0A, 2'b01, 32'h0000_8001);
        tbl[0] = '{7'h04, 2'b10, 1'b0, 32'h1234_AB78};
        tbl[1] = '{7'h05, 2'b00, 1'b1, 32'hFFFF_FFAB};
        tbl[2] = '{7'h05, 2'b00, 1'b0, 32'h0000_00AB};
        tbl[3] = '{7'h0A, 2'b01, 1'b1, 32'hFFFF_8001};
        tbl[4] = '{7'h0A, 2'b01, 1'b0, 32'h0000_8001};
        tbl[5] = '{7'h08, 2'b10, 1'b0, 32'h8001_0000};
        foreach (tbl[i]) begin
            issue_load(tbl[i].a, tbl[i].sz, tbl[i].sx, tbl[i].e);
            n_cmp++;
            if (read_valid !== 1'b1) begin
                n_mis++;
                $display("FAIL subword_rv[%0d]: read_valid=%b, need 1", i, read_valid);
            end
            got = exp_q.pop_front();
            last_exp = got;
            n_cmp++;
            if (data_out !== got) begin
                n_mis++;
                $display("FAIL subword_data[%0d]: data_out=%h, need %h", i, data_out, got);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [6:0]  ta [4];
        logic [1:0]  ts [4];
        logic [1:0]  tw [4];
        logic [31:0] got;
        ta = '{7'h06, 7'h03, 7'h00, 7'h01};
        ts = '{2'b10, 2'b01, 2'b11, 2'b01};
        tw = '{2'b10, 2'b01, 2'b01, 2'b11};   // {write, read}
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            address = ta[i]; size = ts[i]; data_in = 32'hDEAD_BEEF;
            write_enable = tw[i][1]; read_enable = tw[i][0];
            @(negedge clk);
            write_enable = 1'b0; read_enable = 1'b0;
            n_cmp++;
            if (misaligned !== 1'b1 || read_valid !== 1'b0 || data_out !== last_exp) begin
                n_mis++;
                $display("FAIL misalign_flag[%0d]: mis=%b rv=%b data_out=%h, need 1/0/%h",
                         i, misaligned, read_valid, data_out, last_exp);
            end
            @(negedge clk);
            n_cmp++;
            if (misaligned !== 1'b0) begin
                n_mis++;
                $display("FAIL misalign_single_pulse[%0d]: mis=%b, need 0", i, misaligned);
            end
        end
        issue_load(7'h04, 2'b10, 1'b0, 32'h1234_AB78);
        got = exp_q.pop_front();
        last_exp = got;
        n_cmp++;
        if (read_valid !== 1'b1 || data_out !== got) begin
            n_mis++;
            $display("FAIL misalign_no_store: rv=%b data_out=%h, need 1 and %h", read_valid, data_out, got);
        end
    endtask

    task automatic test_read_first();
        logic [31:0] got;
        issue_store(7'h10, 2'b10, 32'h1111_1111);
        @(negedge clk);
        address = 7'h10; size = 2'b10; sign_ext = 1'b0; data_in = 32'h2222_2222;
        write_enable = 1'b1; read_enable = 1'b1;
        exp_q.push_back(32'h1111_1111);
        @(negedge clk);
        write_enable = 1'b0; read_enable = 1'b0;
        got = exp_q.pop_front();
        last_exp = got;
        n_cmp++;
        if (read_valid !== 1'b1 || data_out !== got) begin
            n_mis++;
            $display("FAIL read_first_old: rv=%b data_out=%h, need 1 and %h", read_valid, data_out, got);
        end
        issue_load(7'h10, 2'b10, 1'b0, 32'h2222_2222);
        got = exp_q.pop_front();
        last_exp = got;
        n_cmp++;
        if (data_out !== got) begin
            n_mis++;
            $display("FAIL read_first_new: data_out=%h, need %h", data_out, got);
        end
    endtask

    task automatic test_back_to_back();
        ld_t tbl [7];
        logic [31:0] got;
        tbl[0] = '{7'h04, 2'b10, 1'b0, 32'h1234_AB78};
        tbl[1] = '{7'h08, 2'b10, 1'b0, 32'h8001_0000};
        tbl[2] = '{7'h10, 2'b10, 1'b0, 32'h2222_2222};
        tbl[3] = '{7'h04, 2'b00, 1'b1, 32'h0000_0078};
        tbl[4] = '{7'h06, 2'b01, 1'b1, 32'h0000_1234};
        tbl[5] = '{7'h0B, 2'b00, 1'b1, 32'hFFFF_FF80};
        tbl[6] = '{7'h7C, 2'b10, 1'b0, 32'h0000_0000};
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (read_valid !== 1'b1) begin
                    n_mis++;
                    $display("FAIL b2b_rv[%0d]: read_valid=%b, need 1", i - 1, read_valid);
                end
                got = exp_q.pop_front();
                last_exp = got;
                n_cmp++;
                if (data_out !== got) begin
                    n_mis++;
                    $display("FAIL b2b_data[%0d]: data_out=%h, need %h", i - 1, data_out, got);
                end
            end
            if (i < 7) begin
                address = tbl[i].a; size = tbl[i].sz; sign_ext = tbl[i].sx; read_enable = 1'b1;
                exp_q.push_back(tbl[i].e);
            end else begin
                read_enable = 1'b0;
            end
        end
    endtask

    task automatic test_debug();
        @(negedge clk);
        dbg_address = 5'd1;
        @(negedge clk);
        n_cmp++;
        if (dbg_data !== 32'h1234_AB78) begin
            n_mis++;
            $display("FAIL dbg_word1: dbg_data=%h, need 1234ab78", dbg_data);
        end
        dbg_address = 5'd4;
        issue_store(7'h10, 2'b10, 32'h3333_3333);
        n_cmp++;
        if (dbg_data !== 32'h2222_2222) begin
            n_mis++;
            $display("FAIL dbg_read_first: dbg_data=%h, need 22222222", dbg_data);
        end
        @(negedge clk);
        n_cmp++;
        if (dbg_data !== 32'h3333_3333) begin
            n_mis++;
            $display("FAIL dbg_after_store: dbg_data=%h, need 33333333", dbg_data);
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        int bad;
        @(negedge clk);
        address = 7'h0C; size = 2'b10; data_in = 32'h5555_5555;
        write_enable = 1'b1; read_enable = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        write_enable = 1'b0; read_enable = 1'b0;
        n_cmp++;
        if (read_valid !== 1'b0 || busy !== 1'b1 || dbg_data !== 32'h0) begin
            n_mis++;
            $display("FAIL midreset_outputs: rv=%b busy=%b dbg=%h, need 0/1/0", read_valid, busy, dbg_data);
        end
        @(negedge clk);
        rst = 1'b1;
        dbg_address = 5'd3;
        cycles = 0; bad = 0;
        while (busy === 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (read_valid !== 1'b0 || dbg_data !== 32'h0) bad++;
        end
        n_cmp++;
        if (cycles != 32 || bad != 0) begin
            n_mis++;
            $display("FAIL midreset_sweep: busy cycles=%0d bad=%0d, need 32 and 0", cycles, bad);
        end
        @(negedge clk);
        dbg_address = 5'd1;
        @(negedge clk);
        n_cmp++;
        if (dbg_data !== 32'h0) begin
            n_mis++;
            $display("FAIL midreset_cleared: dbg_data=%h, need 00000000", dbg_data);
        end
        dbg_address = 5'd3;
        @(negedge clk);
        n_cmp++;
        if (dbg_data !== 32'h0) begin
            n_mis++;
            $display("FAIL midreset_store_lost: dbg_data=%h, need 00000000", dbg_data);
        end
        dbg_address = 5'd2;
        issue_store(7'h08, 2'b10, 32'h0000_CAFE);
        @(negedge clk);
        n_cmp++;
        if (dbg_data !== 32'h0000_CAFE) begin
            n_mis++;
            $display("FAIL midreset_dbg_store: dbg_data=%h, need 0000cafe", dbg_data);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        last_exp = '0;
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_read_first();
        test_back_to_back();
        test_debug();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

endmodule
